// File: rtl/robot_pkg.sv
// Shared definitions for the robot FSM and its command sequencer.
// Holds the instruction/command-word widths, the END code and the
// sequencer state encoding.
package robot_pkg;

    localparam int unsigned INSTR_W = 3;
    localparam int unsigned CMD_W   = INSTR_W + 1;

    // Program terminator; never presented to the robot FSM.
    localparam logic [INSTR_W-1:0] INSTR_END = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD,
        ST_PAUSE,
        ST_DONE
    } seq_state_t;

    // Command word layout: {instr[2:0], o}
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               o;
    } cmd_t;

endpackage

// File: rtl/robot_prog_mem.sv
// Program store for the command sequencer: DEPTH x CMD_W register file,
// one synchronous write port, one asynchronous read port. No reset.
//   clk     - system clock, rising edge
//   wr_en   - write strobe (already qualified by the caller)
//   wr_addr - slot to write
//   wr_data - command word {instr, o}
//   rd_addr - slot to read
//   rd_data - command word at rd_addr (combinational)
module robot_prog_mem
    import robot_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CMD_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [CMD_W-1:0] rd_data
);

    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/robot_cmd_sequencer.sv
// Command sequencer feeding the robot FSM. Plays a stored program of
// {instr, o} words, presenting each for HOLD_CYCLES cycles, pausing while
// the obstacle sensor S is high, and stopping on the END code or after the
// last slot.
//   clk, reset        - clock (rising edge), async active-high reset
//   wr_en/addr/data   - program write port, ignored while busy
//   start             - playback start pulse, honoured in IDLE or DONE
//   S                 - obstacle sensor
//   I_2, I_1, I_0, O  - registered instruction and O bit to the robot FSM
//   busy              - high in ISSUE, HOLD and PAUSE
//   done              - high in DONE
//   pc                - current program slot
module robot_cmd_sequencer
    import robot_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             start,
    input  logic             S,
    output logic             I_2,
    output logic             I_1,
    output logic             I_0,
    output logic             O,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    pc
);

    localparam int unsigned   CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

    seq_state_t         state;
    logic [CW-1:0]      hold_cnt;
    logic [AW-1:0]      pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               o_q;
    logic               busy_q;
    logic               done_q;

    logic               mem_we;
    logic [CMD_W-1:0]   rd_data;
    cmd_t               rd_cmd;

    assign mem_we = wr_en && !busy_q;
    assign rd_cmd = rd_data;

    robot_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            o_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_ISSUE;
                        pc_q   <= '0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    if (rd_cmd.instr == INSTR_END) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state    <= ST_HOLD;
                        instr_q  <= rd_cmd.instr;
                        o_q      <= rd_cmd.o;
                        hold_cnt <= HOLD_LOAD;
                    end
                end

                ST_HOLD: begin
                    if (S) begin
                        state <= ST_PAUSE;
                        o_q   <= 1'b0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end else if (pc_q != LAST_SLOT) begin
                        pc_q  <= pc_q + AW'(1);
                        state <= ST_ISSUE;
                    end else begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end

                // The S-low edge that leaves PAUSE is itself a hold cycle, so a
                // pause lengthens the command by exactly its S-high cycles. When
                // the frozen count is already exhausted the slot ends right here.
                ST_PAUSE: begin
                    if (!S) begin
                        o_q <= rd_cmd.o;
                        if (hold_cnt != '0) begin
                            state    <= ST_HOLD;
                            hold_cnt <= hold_cnt - CW'(1);
                        end else if (pc_q != LAST_SLOT) begin
                            pc_q  <= pc_q + AW'(1);
                            state <= ST_ISSUE;
                        end else begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        state  <= ST_ISSUE;
                        pc_q   <= '0;
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else begin
                        instr_q <= '0;
                        o_q     <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign I_2  = instr_q[2];
    assign I_1  = instr_q[1];
    assign I_0  = instr_q[0];
    assign O    = o_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pc   = pc_q;

endmodule
